sc_trigger_ctrl: RTL and testbench

// - Sequences the Schmidl-Cox detector between peak finder and periodic framer.
// - Gates the peak-finder trigger stream: forwards at most one trigger per burst, then drops triggers for a programmable holdoff.
// - Runs a search timeout, supports one-shot or continuous arming, and publishes the peak-finder threshold scalar.
// - Configured from the settings bus at BASE.

---
 rtl/sc_trigger_ctrl_pkg.sv | 39 +++
 rtl/sc_trigger_ctrl_timer.sv | 60 ++++++
 rtl/sc_trigger_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_sc_trigger_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_trigger_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sc_trigger_ctrl_pkg
// Shared definitions for the Schmidl-Cox trigger controller:
//   - settings-bus register offsets relative to the block base address
//   - CTRL register bit positions
//   - controller state encoding (3 bits)
//   - address helper used by the register decode
// ---------------------------------------------------------------------------
package sc_trigger_ctrl_pkg;

    // Register offsets from BASE
    localparam logic [7:0] SR_CTRL    = 8'd0;
    localparam logic [7:0] SR_HOLDOFF = 8'd1;
    localparam logic [7:0] SR_TIMEOUT = 8'd2;
    localparam logic [7:0] SR_THRESH  = 8'd3;

    // CTRL register bit indices
    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_ONESHOT_BIT = 1;
    localparam int unsigned CTRL_REARM_BIT   = 2;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_FORWARD = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_DONE    = 3'd4
    } sc_state_e;

    // Absolute settings-bus address of a register; the bus is 8 bits wide,
    // so the base wraps modulo 256 like the address decoder does.
    function automatic logic [7:0] sc_reg_addr(input int base, input logic [7:0] offset);
        logic [7:0] base_s;
        base_s = 8'(base);
        return base_s + offset;
    endfunction

endpackage

// File: rtl/sc_trigger_ctrl_timer.sv
// ---------------------------------------------------------------------------
// sc_sample_timer
// Sample counter with a programmable limit. Counts sample_stb pulses while
// run is high and signals expire on the sample that completes the count.
//   clk        in   clock
//   aresetn    in   asynchronous active-low reset
//   clear      in   synchronous counter clear (wins over counting)
//   run        in   counting window
//   sample_stb in   one pulse per consumed sample
//   limit      in   number of samples to expire; 0 never expires
//   expire     out  combinational, high on the sample_stb that hits the limit
// The comparison is ">= limit-1" so that lowering the limit below the
// current count expires on the very next sample instead of wrapping.
// ---------------------------------------------------------------------------
module sc_sample_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             run,
    input  logic             sample_stb,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_r;
    logic             expire_s;

    // Expiry decode against the live limit value
    always_comb begin
        expire_s = 1'b0;
        if (run && sample_stb && (limit != {CNT_W{1'b0}}) &&
            (cnt_r >= (limit - CNT_W'(1)))) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Sample counter: cleared on demand or on expiry, else counts samples
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (run && sample_stb) begin
            if (expire_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = expire_s;

endmodule

// File: rtl/sc_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// sc_trigger_ctrl
// Sequences the Schmidl-Cox detector between the peak finder and the
// periodic framer. Forwards at most one trigger per burst, then drops
// triggers for a holdoff of HOLDOFF samples. Runs a search timeout, supports
// one-shot or continuous arming, and publishes the peak-finder threshold.
// Ports:
//   clk, aresetn                     clock, async active-low reset
//   set_stb/set_addr/set_data        settings bus (regs BASE+0..BASE+3)
//   sample_stb                       one pulse per framer sample
//   i_tdata/i_tlast/i_tvalid/i_tready  trigger input from peak finder
//   o_tdata/o_tlast/o_tvalid/o_tready  gated trigger to framer
//   thresh                           threshold scalar for peak finder
//   armed                            high while searching
//   timeout_stb                      one-cycle pulse on search timeout
//   det_count                        forwarded-trigger count (wraps)
// ---------------------------------------------------------------------------
module sc_trigger_ctrl
    import sc_trigger_ctrl_pkg::*;
#(
    parameter int          BASE        = 0,
    parameter int          CNT_W       = 24,
    parameter logic [31:0] THRESH_INIT = 32'd131072
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        sample_stb,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [31:0] thresh,
    output logic        armed,
    output logic        timeout_stb,
    output logic [15:0] det_count
);

    localparam logic [7:0] ADDR_CTRL    = sc_reg_addr(BASE, SR_CTRL);
    localparam logic [7:0] ADDR_HOLDOFF = sc_reg_addr(BASE, SR_HOLDOFF);
    localparam logic [7:0] ADDR_TIMEOUT = sc_reg_addr(BASE, SR_TIMEOUT);
    localparam logic [7:0] ADDR_THRESH  = sc_reg_addr(BASE, SR_THRESH);

    // Settings registers
    logic             enable_r;
    logic             oneshot_r;
    logic [CNT_W-1:0] holdoff_r;
    logic [CNT_W-1:0] timeout_r;
    logic [31:0]      thresh_r;

    // Write decode
    logic wr_ctrl_s;
    logic wr_holdoff_s;
    logic wr_timeout_s;
    logic wr_thresh_s;
    logic rearm_s;

    // FSM
    sc_state_e state_r;
    sc_state_e state_next_s;
    logic      capture_s;
    logic      handshake_s;
    logic      timeout_hit_s;

    // Timers
    logic t_run_s;
    logic h_run_s;
    logic t_expire_s;
    logic h_expire_s;

    // Registered outputs
    logic [31:0] o_tdata_r;
    logic        o_tlast_r;
    logic        o_tvalid_r;
    logic        i_tready_r;
    logic        armed_r;
    logic        timeout_stb_r;
    logic [15:0] det_count_r;

    // Settings-bus address decode; rearm is a pulse straight off the strobe
    always_comb begin
        wr_ctrl_s    = set_stb && (set_addr == ADDR_CTRL);
        wr_holdoff_s = set_stb && (set_addr == ADDR_HOLDOFF);
        wr_timeout_s = set_stb && (set_addr == ADDR_TIMEOUT);
        wr_thresh_s  = set_stb && (set_addr == ADDR_THRESH);
        rearm_s      = wr_ctrl_s && set_data[CTRL_REARM_BIT];
    end

    // Settings register file; new values take effect from the next cycle
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            enable_r  <= 1'b0;
            oneshot_r <= 1'b0;
            holdoff_r <= {CNT_W{1'b0}};
            timeout_r <= {CNT_W{1'b0}};
            thresh_r  <= THRESH_INIT;
        end else begin
            if (wr_ctrl_s) begin
                enable_r  <= set_data[CTRL_ENABLE_BIT];
                oneshot_r <= set_data[CTRL_ONESHOT_BIT];
            end else begin
                enable_r  <= enable_r;
                oneshot_r <= oneshot_r;
            end
            if (wr_holdoff_s) begin
                holdoff_r <= set_data[CNT_W-1:0];
            end else begin
                holdoff_r <= holdoff_r;
            end
            if (wr_timeout_s) begin
                timeout_r <= set_data[CNT_W-1:0];
            end else begin
                timeout_r <= timeout_r;
            end
            if (wr_thresh_s) begin
                thresh_r <= set_data;
            end else begin
                thresh_r <= thresh_r;
            end
        end
    end

    // Timers only run in their own state and are held clear elsewhere, so
    // every entry into SEARCH/HOLDOFF starts from zero.
    always_comb begin
        t_run_s = (state_r == ST_SEARCH);
        h_run_s = (state_r == ST_HOLDOFF);
    end

    sc_sample_timer #(.CNT_W(CNT_W)) u_timeout_timer (
        .clk        (clk),
        .aresetn    (aresetn),
        .clear      (!t_run_s),
        .run        (t_run_s),
        .sample_stb (sample_stb),
        .limit      (timeout_r),
        .expire     (t_expire_s)
    );

    sc_sample_timer #(.CNT_W(CNT_W)) u_holdoff_timer (
        .clk        (clk),
        .aresetn    (aresetn),
        .clear      (!h_run_s),
        .run        (h_run_s),
        .sample_stb (sample_stb),
        .limit      (holdoff_r),
        .expire     (h_expire_s)
    );

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle events
    always_comb begin
        state_next_s  = state_r;
        capture_s     = 1'b0;
        handshake_s   = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_r) begin
                    state_next_s = ST_SEARCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (!enable_r) begin
                    state_next_s = ST_IDLE;
                end else if (i_tvalid && i_tready_r) begin
                    // A trigger beats a coincident timeout
                    capture_s    = 1'b1;
                    state_next_s = ST_FORWARD;
                end else if (t_expire_s) begin
                    timeout_hit_s = 1'b1;
                    state_next_s  = ST_SEARCH;
                end else begin
                    state_next_s = ST_SEARCH;
                end
            end
            ST_FORWARD: begin
                // Disable is deferred until the framer has taken the trigger
                if (o_tready && o_tvalid_r) begin
                    handshake_s = 1'b1;
                    if (!enable_r) begin
                        state_next_s = ST_IDLE;
                    end else if (holdoff_r != {CNT_W{1'b0}}) begin
                        state_next_s = ST_HOLDOFF;
                    end else if (oneshot_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SEARCH;
                    end
                end else begin
                    state_next_s = ST_FORWARD;
                end
            end
            ST_HOLDOFF: begin
                // A holdoff rewritten to zero mid-count ends on the next sample
                if (!enable_r) begin
                    state_next_s = ST_IDLE;
                end else if (h_expire_s ||
                             ((holdoff_r == {CNT_W{1'b0}}) && sample_stb)) begin
                    if (oneshot_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SEARCH;
                    end
                end else begin
                    state_next_s = ST_HOLDOFF;
                end
            end
            ST_DONE: begin
                if (!enable_r) begin
                    state_next_s = ST_IDLE;
                end else if (rearm_s) begin
                    state_next_s = ST_SEARCH;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Gated trigger output stage: capture in SEARCH, hold until handshake
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_tvalid_r <= 1'b0;
            o_tdata_r  <= 32'h0000_0000;
            o_tlast_r  <= 1'b0;
        end else if (capture_s) begin
            o_tvalid_r <= 1'b1;
            o_tdata_r  <= i_tdata;
            o_tlast_r  <= i_tlast;
        end else if (handshake_s) begin
            o_tvalid_r <= 1'b0;
            o_tdata_r  <= o_tdata_r;
            o_tlast_r  <= o_tlast_r;
        end else begin
            o_tvalid_r <= o_tvalid_r;
            o_tdata_r  <= o_tdata_r;
            o_tlast_r  <= o_tlast_r;
        end
    end

    // Status outputs registered from the next state so they track state_r
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            i_tready_r    <= 1'b1;
            armed_r       <= 1'b0;
            timeout_stb_r <= 1'b0;
        end else begin
            i_tready_r    <= (state_next_s != ST_FORWARD);
            armed_r       <= (state_next_s == ST_SEARCH);
            timeout_stb_r <= timeout_hit_s;
        end
    end

    // Forwarded-trigger counter, free-running wrap at 16 bits
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            det_count_r <= 16'h0000;
        end else if (handshake_s) begin
            det_count_r <= det_count_r + 16'h0001;
        end else begin
            det_count_r <= det_count_r;
        end
    end

    assign i_tready    = i_tready_r;
    assign o_tdata     = o_tdata_r;
    assign o_tlast     = o_tlast_r;
    assign o_tvalid    = o_tvalid_r;
    assign thresh      = thresh_r;
    assign armed       = armed_r;
    assign timeout_stb = timeout_stb_r;
    assign det_count   = det_count_r;

endmodule

// File: tb/tb_sc_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc_trigger_ctrl
// Directed bench for sc_trigger_ctrl. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point, so each tick()
// shows the result of exactly one clock edge.
// ---------------------------------------------------------------------------
module tb_sc_trigger_ctrl;

    logic        clk;
    logic        aresetn;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        sample_stb;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [31:0] thresh;
    logic        armed;
    logic        timeout_stb;
    logic [15:0] det_count;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    sc_trigger_ctrl dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .set_stb     (set_stb),
        .set_addr    (set_addr),
        .set_data    (set_data),
        .sample_stb  (sample_stb),
        .i_tdata     (i_tdata),
        .i_tlast     (i_tlast),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .thresh      (thresh),
        .armed       (armed),
        .timeout_stb (timeout_stb),
        .det_count   (det_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        tick();
        set_stb  = 1'b0;
        set_addr = 8'h00;
        set_data = 32'h0;
    endtask

    initial begin : stim
        int          fwd_cnt;
        logic [31:0] last_fwd;
        int          pulses;
        int          pos0;
        int          pos1;
        int          stray;

        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        aresetn = 1'b0; set_stb = 1'b0; set_addr = 8'h00; set_data = 32'h0;
        sample_stb = 1'b0; i_tdata = 32'h0; i_tlast = 1'b0; i_tvalid = 1'b0;
        o_tready = 1'b1;

        // ---- reset state
        #23;
        check("rst_o_tvalid",    32'(o_tvalid),    32'd0);
        check("rst_o_tdata",     o_tdata,          32'h0);
        check("rst_i_tready",    32'(i_tready),    32'd1);
        check("rst_armed",       32'(armed),       32'd0);
        check("rst_timeout_stb", 32'(timeout_stb), 32'd0);
        check("rst_det_count",   32'(det_count),   32'd0);
        check("rst_thresh",      thresh,           32'd131072);
        #1 aresetn = 1'b1;
        tick();

        // ---- basic forward, HOLDOFF=0, TIMEOUT=0
        wr(8'd1, 32'd0);
        wr(8'd2, 32'd0);
        wr(8'd3, 32'h0000_0055);
        check("thresh_write", thresh, 32'h0000_0055);
        wr(8'd0, 32'h1);
        check("idle_not_armed", 32'(armed), 32'd0);
        tick();
        check("search_armed", 32'(armed), 32'd1);
        i_tvalid = 1'b1; i_tdata = 32'h1234_0100; i_tlast = 1'b1;
        tick();
        i_tvalid = 1'b0; i_tlast = 1'b0;
        check("fwd_o_tvalid", 32'(o_tvalid), 32'd1);
        check("fwd_o_tdata",  o_tdata,       32'h1234_0100);
        check("fwd_o_tlast",  32'(o_tlast),  32'd1);
        check("fwd_i_tready", 32'(i_tready), 32'd0);
        tick();
        check("hs1_det_count", 32'(det_count), 32'd1);
        check("hs1_o_tvalid",  32'(o_tvalid),  32'd0);
        check("hs1_armed",     32'(armed),     32'd1);
        check("hs1_i_tready",  32'(i_tready),  32'd1);

        // ---- HOLDOFF=10, trigger every 3 samples: k=0 and k=12 pass
        wr(8'd1, 32'd10);
        fwd_cnt = 0; last_fwd = 32'h0;
        for (int k = 0; k < 18; k++) begin
            sample_stb = 1'b1;
            i_tvalid   = ((k % 3) == 0);
            i_tdata    = 32'(k);
            tick();
            if (o_tvalid) begin
                fwd_cnt++;
                last_fwd = o_tdata;
            end
        end
        sample_stb = 1'b0; i_tvalid = 1'b0;
        check("hold_fwd_cnt",   32'(fwd_cnt),   32'd2);
        check("hold_last_data", last_fwd,       32'd12);
        check("hold_det_count", 32'(det_count), 32'd3);

        wr(8'd0, 32'h0);
        tick();
        check("disable_idle_armed", 32'(armed), 32'd0);

        // ---- backpressure in FORWARD, then disable before handshake
        wr(8'd1, 32'd0);
        wr(8'd0, 32'h1);
        tick();
        check("bp_armed", 32'(armed), 32'd1);
        o_tready = 1'b0;
        i_tvalid = 1'b1; i_tdata = 32'hCAFE_0001;
        tick();
        i_tdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("bp_o_tvalid", 32'(o_tvalid), 32'd1);
            check("bp_o_tdata",  o_tdata,       32'hCAFE_0001);
            check("bp_i_tready", 32'(i_tready), 32'd0);
        end
        wr(8'd0, 32'h0);
        tick();
        check("bp_dis_o_tvalid", 32'(o_tvalid), 32'd1);
        check("bp_dis_i_tready", 32'(i_tready), 32'd0);
        o_tready = 1'b1;
        tick();
        check("bp_hs_o_tvalid",  32'(o_tvalid),  32'd0);
        check("bp_hs_i_tready",  32'(i_tready),  32'd1);
        check("bp_hs_armed",     32'(armed),     32'd0);
        check("bp_hs_det_count", 32'(det_count), 32'd4);
        tick();
        check("idle_drop_o_tvalid", 32'(o_tvalid), 32'd0);
        i_tvalid = 1'b0;

        // ---- TIMEOUT=50, 120 samples, no triggers
        wr(8'd2, 32'd50);
        wr(8'd0, 32'h1);
        tick();
        pulses = 0; pos0 = 0; pos1 = 0;
        for (int s = 1; s <= 120; s++) begin
            sample_stb = 1'b1;
            tick();
            if (timeout_stb) begin
                if (pulses == 0) pos0 = s;
                if (pulses == 1) pos1 = s;
                pulses++;
            end
        end
        sample_stb = 1'b0;
        check("to_pulses", 32'(pulses), 32'd2);
        check("to_pos0",   32'(pos0),   32'd50);
        check("to_pos1",   32'(pos1),   32'd100);

        // ---- trigger on the 50th sample wins over the timeout
        wr(8'd0, 32'h0);
        wr(8'd0, 32'h1);
        tick();
        stray = 0;
        for (int s = 1; s < 50; s++) begin
            sample_stb = 1'b1;
            tick();
            if (timeout_stb) stray++;
        end
        i_tvalid = 1'b1; i_tdata = 32'h0050_0050;
        tick();
        sample_stb = 1'b0; i_tvalid = 1'b0;
        check("to_stray",        32'(stray),       32'd0);
        check("to_trig_nopulse", 32'(timeout_stb), 32'd0);
        check("to_trig_valid",   32'(o_tvalid),    32'd1);
        check("to_trig_data",    o_tdata,          32'h0050_0050);
        tick();
        check("to_trig_det", 32'(det_count), 32'd5);

        // ---- oneshot: second trigger dropped in DONE, rearm restarts
        wr(8'd2, 32'd0);
        wr(8'd0, 32'h3);
        i_tvalid = 1'b1; i_tdata = 32'h0000_00A1;
        tick();
        i_tvalid = 1'b0;
        check("os_a_data", o_tdata, 32'h0000_00A1);
        tick();
        check("os_done_armed",   32'(armed),    32'd0);
        check("os_done_i_tready",32'(i_tready), 32'd1);
        i_tvalid = 1'b1; i_tdata = 32'h0000_00B2;
        tick();
        i_tvalid = 1'b0;
        check("os_b_dropped", 32'(o_tvalid), 32'd0);
        tick();
        check("os_b_det", 32'(det_count), 32'd6);
        wr(8'd0, 32'h7);
        check("os_rearm_armed", 32'(armed), 32'd1);
        i_tvalid = 1'b1; i_tdata = 32'h0000_00C3;
        tick();
        i_tvalid = 1'b0;
        check("os_c_data", o_tdata, 32'h0000_00C3);
        tick();
        check("os_c_det",   32'(det_count), 32'd7);
        check("os_c_armed", 32'(armed),     32'd0);

        // ---- async reset during FORWARD
        wr(8'd0, 32'h7);
        o_tready = 1'b0;
        i_tvalid = 1'b1; i_tdata = 32'h0000_00D4;
        tick();
        i_tvalid = 1'b0;
        check("ar_pre_valid", 32'(o_tvalid), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("ar_o_tvalid",  32'(o_tvalid),  32'd0);
        check("ar_thresh",    thresh,         32'd131072);
        check("ar_det_count", 32'(det_count), 32'd0);
        check("ar_armed",     32'(armed),     32'd0);
        check("ar_i_tready",  32'(i_tready),  32'd1);
        #2 aresetn = 1'b1;
        o_tready = 1'b1;
        tick();
        tick();
        check("ar_idle_armed",  32'(armed),    32'd0);
        check("ar_idle_tvalid", 32'(o_tvalid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
